alu_bitserial_seq: RTL

Bit-serial 32-bit ALU sequencer. It drives the same 1-bit slice function as the team's ALU bit slice, once per clock over 32 bit positions. Operands and opcode are accepted through a valid/ready handshake. One result is returned per operation through a second valid/ready handshake. It is the sequential driver that iterates the slice, using the slice opcode map, the carry chain and the Less/SLT convention.

---
 rtl/alu_bitserial_seq_if.sv | 27 ++
 rtl/alu_bitserial_seq.sv | 150 +++++++++++++++
 2 files changed

// File: rtl/alu_bitserial_seq_if.sv
// Request/response bundle for the bit-serial ALU sequencer.
// The master issues operands and consumes results; the slave is the sequencer.
interface alu_bitserial_seq_if #(
  parameter int unsigned WIDTH = 32
) ();
  logic             start_valid;
  logic             start_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [2:0]       op;
  logic             result_valid;
  logic             result_ready;
  logic [WIDTH-1:0] result;
  logic             cout;
  logic             overflow;
  logic             zero;

  modport master (
    output start_valid, a, b, op, result_ready,
    input  start_ready, result_valid, result, cout, overflow, zero
  );

  modport slave (
    input  start_valid, a, b, op, result_ready,
    output start_ready, result_valid, result, cout, overflow, zero
  );
endinterface

// File: rtl/alu_bitserial_seq.sv
// Bit-serial ALU sequencer: iterates a 1-bit AND/OR/ADD/SUB/SLT slice over WIDTH bits,
// one bit per clock, with valid/ready handshakes on request and result.
module alu_bitserial_seq #(
  parameter int unsigned WIDTH = 32
) (
  input logic                clk,
  input logic                reset,
  alu_bitserial_seq_if.slave bus
);
  localparam int unsigned IdxW = $clog2(WIDTH);
  localparam logic [IdxW-1:0] LastIdx = IdxW'(WIDTH - 1);

  localparam logic [2:0] OpAnd = 3'b000;
  localparam logic [2:0] OpOr  = 3'b001;
  localparam logic [2:0] OpAdd = 3'b010;
  localparam logic [2:0] OpSub = 3'b110;
  localparam logic [2:0] OpSlt = 3'b111;

  typedef enum logic [1:0] {StIdle, StCompute, StFinish, StDone} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, acc_q, acc_d, result_q, result_d;
  logic [2:0]       op_q, op_d;
  logic [IdxW-1:0]  idx_q, idx_d;
  logic             carry_q, carry_d, cin_msb_q, cin_msb_d;
  logic             cout_q, cout_d, ovf_q, ovf_d, zero_q, zero_d;

  logic             ai, bi, sum_bit, res_bit, is_arith, ovf_calc;
  logic [WIDTH-1:0] res_fin;

  always_comb begin
    state_d   = state_q;
    a_d       = a_q;
    b_d       = b_q;
    op_d      = op_q;
    idx_d     = idx_q;
    carry_d   = carry_q;
    cin_msb_d = cin_msb_q;
    acc_d     = acc_q;
    result_d  = result_q;
    cout_d    = cout_q;
    ovf_d     = ovf_q;
    zero_d    = zero_q;
    res_fin   = '0;
    res_bit   = 1'b0;

    // op[2] doubles as Binvert and the carry-in for SUB/SLT.
    ai       = a_q[idx_q];
    bi       = b_q[idx_q] ^ op_q[2];
    sum_bit  = ai ^ bi ^ carry_q;
    is_arith = (op_q == OpAdd) || (op_q == OpSub) || (op_q == OpSlt);
    ovf_calc = cin_msb_q ^ carry_q;

    unique case (state_q)
      StIdle: begin
        if (bus.start_valid) begin
          a_d     = bus.a;
          b_d     = bus.b;
          op_d    = bus.op;
          carry_d = bus.op[2];
          idx_d   = '0;
          acc_d   = '0;
          state_d = StCompute;
        end
      end
      StCompute: begin
        case (op_q)
          OpAnd:   res_bit = ai & bi;
          OpOr:    res_bit = ai | bi;
          default: res_bit = sum_bit;
        endcase
        acc_d[idx_q] = res_bit;
        if (is_arith) begin
          carry_d = (ai & bi) | (ai & carry_q) | (bi & carry_q);
        end
        if (idx_q == LastIdx) begin
          cin_msb_d = carry_q;
          state_d   = StFinish;
        end else begin
          idx_d = idx_q + IdxW'(1);
        end
      end
      StFinish: begin
        cout_d = 1'b0;
        ovf_d  = 1'b0;
        case (op_q)
          OpAnd, OpOr: res_fin = acc_q;
          OpAdd, OpSub: begin
            res_fin = acc_q;
            cout_d  = carry_q;
            ovf_d   = ovf_calc;
          end
          OpSlt: begin
            // Sign of the difference corrected by overflow gives a signed compare.
            res_fin = {{(WIDTH-1){1'b0}}, acc_q[WIDTH-1] ^ ovf_calc};
            cout_d  = carry_q;
            ovf_d   = ovf_calc;
          end
          default: res_fin = '0;
        endcase
        result_d = res_fin;
        zero_d   = (res_fin == '0);
        state_d  = StDone;
      end
      StDone: begin
        if (bus.result_ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= StIdle;
      a_q       <= '0;
      b_q       <= '0;
      op_q      <= '0;
      idx_q     <= '0;
      carry_q   <= 1'b0;
      cin_msb_q <= 1'b0;
      acc_q     <= '0;
      result_q  <= '0;
      cout_q    <= 1'b0;
      ovf_q     <= 1'b0;
      zero_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      a_q       <= a_d;
      b_q       <= b_d;
      op_q      <= op_d;
      idx_q     <= idx_d;
      carry_q   <= carry_d;
      cin_msb_q <= cin_msb_d;
      acc_q     <= acc_d;
      result_q  <= result_d;
      cout_q    <= cout_d;
      ovf_q     <= ovf_d;
      zero_q    <= zero_d;
    end
  end

  assign bus.start_ready  = (state_q == StIdle);
  assign bus.result_valid = (state_q == StDone);
  assign bus.result       = result_q;
  assign bus.cout         = cout_q;
  assign bus.overflow     = ovf_q;
  assign bus.zero         = zero_q;
endmodule
